// File: rtl/uart_rx_fifo_writer.sv
// UART 8N1 receiver that pushes each good byte into the write side of the
// asynchronous FIFO. It runs in the FIFO write-clock domain and reports
// framing errors and bytes dropped while the FIFO is full.
module uart_rx_fifo_writer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  full,
    input  logic                  ovf_clr,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  prev_q, prev_d;
    logic [1:0]            settle_q, settle_d;
    logic                  armed_q, armed_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  w_en_q, w_en_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  busy_q, busy_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;
    logic                  ovf_set_s;

    // Next-state logic: synchroniser, start arming, frame FSM and output strobes.
    always_comb begin
        sync1_d     = rx;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        // The synchroniser powers up high; only trust it once real samples
        // have flushed through, so a line held low across reset is no start.
        if (settle_q == 2'd3) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 2'd1;
        end
        armed_d     = armed_q | ((settle_q == 2'd3) & sync2_q);
        state_d     = state_q;
        if (bit_cnt_q == CNT_LAST) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
        end
        idx_d       = idx_q;
        shift_d     = shift_q;
        w_en_d      = 1'b0;
        data_out_d  = data_out_q;
        frame_err_d = 1'b0;
        ovf_set_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (armed_q && prev_q && !sync2_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_cnt_q == CNT_HALF) begin
                    if (!sync2_q) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_cnt_q == CNT_LAST) begin
                    shift_d = {sync2_q, shift_q[DATA_WIDTH-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_cnt_q == CNT_LAST) begin
                    if (sync2_q) begin
                        // Leaving at mid stop bit leaves half a bit to catch the next start.
                        if (!full) begin
                            w_en_d     = 1'b1;
                            data_out_d = shift_q;
                        end else begin
                            ovf_set_s  = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK: begin
                bit_cnt_d = '0;
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end

        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; async reset returns to an idle line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            w_en_q      <= 1'b0;
            data_out_q  <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            w_en_q      <= w_en_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign w_en      = w_en_q;
    assign data_out  = data_out_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed bench for uart_rx_fifo_writer with 16 clocks per bit.
module tb_uart_rx_fifo_writer;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       full;
    logic       ovf_clr;
    logic       w_en;
    logic [7:0] data_out;
    logic       busy;
    logic       frame_err;
    logic       overflow;

    int total;
    int bad;
    int cyc;
    int t_start;
    int lat_last;
    int ferr_cnt;
    int dbl_cnt;
    int wfull_cnt;
    int busy_low;
    logic in_win;
    logic w_en_prev;
    logic [7:0] wr_q[$];

    uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .full      (full),
        .ovf_clr   (ovf_clr),
        .w_en      (w_en),
        .data_out  (data_out),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output monitor: sampled 1 time unit after each rising edge.
    initial begin
        cyc = 0; lat_last = 0; ferr_cnt = 0; dbl_cnt = 0; wfull_cnt = 0;
        busy_low = 0; w_en_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (w_en === 1'b1) begin
                wr_q.push_back(data_out);
                lat_last = cyc - t_start;
                if (w_en_prev === 1'b1) dbl_cnt = dbl_cnt + 1;
                if (full === 1'b1) wfull_cnt = wfull_cnt + 1;
            end
            if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
            if (in_win === 1'b1 && busy === 1'b0) busy_low = busy_low + 1;
            w_en_prev = w_en;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called right after a falling clock edge; ends right after one.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        t_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; t_start = 0; in_win = 1'b0;
        rst = 1'b1; rx = 1'b1; full = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_w_en", {31'd0, w_en}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 1: single byte, latency
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("t1_count", wr_q.size(), 32'd1);
        if (wr_q.size() >= 1) check("t1_data", {24'd0, wr_q[0]}, 32'h0000_00A5);
        check("t1_lat_ok", {31'd0, (lat_last >= 153 && lat_last <= 155)}, 32'd1);
        check("t1_ferr", ferr_cnt, 32'd0);
        check("t1_ovf", {31'd0, overflow}, 32'd0);

        // 2: back-to-back frames
        repeat (10) @(negedge clk);
        in_win = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        in_win = 1'b0;
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        check("t2_count", wr_q.size(), 32'd4);
        if (wr_q.size() >= 4) begin
            check("t2_d0", {24'd0, wr_q[1]}, 32'h0000_0000);
            check("t2_d1", {24'd0, wr_q[2]}, 32'h0000_00FF);
            check("t2_d2", {24'd0, wr_q[3]}, 32'h0000_003C);
        end
        check("t2_busy_gap", {31'd0, (busy_low >= 14 && busy_low <= 22)}, 32'd1);

        // 3: overflow while full
        full = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        check("t3_nowrite", wr_q.size(), 32'd4);
        check("t3_ovf_set", {31'd0, overflow}, 32'd1);
        repeat (50) @(negedge clk);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t3_ovf_clr", {31'd0, overflow}, 32'd0);
        full = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        check("t3_count", wr_q.size(), 32'd5);
        if (wr_q.size() >= 5) check("t3_data", {24'd0, wr_q[4]}, 32'h0000_0011);

        // 4: framing error then long break
        send_byte(8'hC3, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        check("t4_ferr_once", ferr_cnt, 32'd1);
        check("t4_nowrite", wr_q.size(), 32'd5);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        send_byte(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        check("t4_count", wr_q.size(), 32'd6);
        if (wr_q.size() >= 6) check("t4_data", {24'd0, wr_q[5]}, 32'h0000_007E);

        // 5: short glitch is a false start
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_busy_start", {31'd0, busy}, 32'd1);
        repeat (40) @(negedge clk);
        check("t5_idle", {31'd0, busy}, 32'd0);
        check("t5_nowrite", wr_q.size(), 32'd6);
        check("t5_noferr", ferr_cnt, 32'd1);

        // 6: reset during data bit 4
        fork
            send_byte(8'h96, 1'b1);
            begin
                repeat (88) @(negedge clk);
                check("t6_busy_pre", {31'd0, busy}, 32'd1);
                rst = 1'b1;
                #1;
                check("t6_rst_busy", {31'd0, busy}, 32'd0);
                check("t6_rst_data", {24'd0, data_out}, 32'd0);
                check("t6_rst_w_en", {31'd0, w_en}, 32'd0);
                check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
                check("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
            end
        join
        rx = 1'b1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_nowrite", wr_q.size(), 32'd6);
        send_byte(8'h96, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_count", wr_q.size(), 32'd7);
        if (wr_q.size() >= 7) check("t6_data", {24'd0, wr_q[6]}, 32'h0000_0096);

        check("never_double_w_en", dbl_cnt, 32'd0);
        check("never_write_full", wfull_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
